// File: rtl/chip8_pkg.sv
// Shared types and opcode constants for the Chip8 instruction-side logic.
package chip8_pkg;

  localparam logic [11:0] PROG_START_DEFAULT = 12'h200;

  typedef enum logic [2:0] {
    IDLE,
    F_HI,
    F_LO,
    F_WAIT,
    EXEC,
    MULTI,
    FAULT
  } state_t;

  localparam logic [3:0]  OP_JP     = 4'h1;
  localparam logic [3:0]  OP_CALL   = 4'h2;
  localparam logic [3:0]  OP_SE     = 4'h3;
  localparam logic [3:0]  OP_SNE    = 4'h4;
  localparam logic [3:0]  OP_SEV    = 4'h5;
  localparam logic [3:0]  OP_SNEV   = 4'h9;
  localparam logic [3:0]  OP_JPV0   = 4'hB;
  localparam logic [3:0]  OP_F      = 4'hF;
  localparam logic [7:0]  FN_STORE  = 8'h55;
  localparam logic [7:0]  FN_LOAD   = 8'h65;
  localparam logic [15:0] INSTR_RET = 16'h00EE;

  // Fx55/Fx65 walk registers V0..Vx, one per exec cycle.
  function automatic logic is_multi(input logic [15:0] ir);
    return (ir[15:12] == OP_F) && ((ir[7:0] == FN_STORE) || (ir[7:0] == FN_LOAD));
  endfunction

endpackage

// File: rtl/chip8_fetch_sequencer_if.sv
// Program-memory read port plus the opcode/register-address link to the combinational CPU.
interface chip8_fetch_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_readdata;
  logic [15:0]       instruction;
  logic [3:0]        control;
  logic              exec;
  logic [3:0]        vx_addr;
  logic [3:0]        vy_addr;
  logic [7:0]        vx_data;
  logic [7:0]        vy_data;

  modport master (
    output mem_addr, mem_rd, instruction, control, exec, vx_addr, vy_addr,
    input  mem_readdata, vx_data, vy_data
  );

  modport slave (
    input  mem_addr, mem_rd, instruction, control, exec, vx_addr, vy_addr,
    output mem_readdata, vx_data, vy_data
  );
endinterface

// File: rtl/chip8_call_stack.sv
// Return-address LIFO; only the stack pointer is reset, entries hold whatever was pushed.
module chip8_call_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 12
) (
  input  logic             cpu_clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_dec;

  assign full   = (sp == SP_W'(DEPTH));
  assign empty  = (sp == '0);
  assign sp_dec = sp - SP_W'(1);
  assign top    = entries[sp_dec[IDX_W-1:0]];

  // NOTE: the entry array has no reset; a reset loop over memory would block RAM inference and add nothing, since sp gates every read.
  always_ff @(posedge cpu_clk) begin
    if (push && !full) entries[sp[IDX_W-1:0]] <= push_data;
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n)              sp <= '0;
    else if (push && !full)    sp <= sp + SP_W'(1);
    else if (pop && !empty)    sp <= sp - SP_W'(1);
  end

endmodule

// File: rtl/chip8_fetch_sequencer.sv
// Fetch FSM, PC and control-flow resolution feeding the combinational Chip8 CPU.
module chip8_fetch_sequencer
  import chip8_pkg::*;
#(
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] PROG_START  = ADDR_W'(PROG_START_DEFAULT),
  parameter int                STACK_DEPTH = 16
) (
  input  logic                    cpu_clk,
  input  logic                    reset_n,
  input  logic                    run,
  chip8_fetch_sequencer_if.master bus,
  output logic [ADDR_W-1:0]       pc,
  output logic                    fault
);
  state_t            state;
  logic [7:0]        ir_hi;
  logic [3:0]        op;
  logic [ADDR_W-1:0] nnn, pc_seq, pc_skip, next_pc, stack_top;
  logic              last_step, retire;
  logic              push, pop, stack_fault, full, empty;

  assign op        = bus.instruction[15:12];
  assign nnn       = ADDR_W'(bus.instruction[11:0]);
  assign last_step = !is_multi(bus.instruction) || (bus.control == bus.instruction[11:8]);
  assign retire    = ((state == EXEC) || (state == MULTI)) && last_step;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    pc_seq      = pc + ADDR_W'(2);
    pc_skip     = pc + ADDR_W'(4);
    next_pc     = pc_seq;
    push        = 1'b0;
    pop         = 1'b0;
    stack_fault = 1'b0;
    if (bus.instruction == INSTR_RET) begin
      if (empty) stack_fault = 1'b1;
      else begin
        pop     = retire;
        next_pc = stack_top;
      end
    end else begin
      case (op)
        OP_JP:   next_pc = nnn;
        OP_CALL: begin
          if (full) stack_fault = 1'b1;
          else begin
            push    = retire;
            next_pc = nnn;
          end
        end
        OP_SE:   if (bus.vx_data == bus.instruction[7:0]) next_pc = pc_skip;
        OP_SNE:  if (bus.vx_data != bus.instruction[7:0]) next_pc = pc_skip;
        OP_SEV:  if (bus.instruction[3:0] == 4'h0 && bus.vx_data == bus.vy_data) next_pc = pc_skip;
        OP_SNEV: if (bus.instruction[3:0] == 4'h0 && bus.vx_data != bus.vy_data) next_pc = pc_skip;
        OP_JPV0: next_pc = nnn + ADDR_W'(bus.vx_data);
        default: ;
      endcase
    end
  end

  chip8_call_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .cpu_clk   (cpu_clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_seq),
    .top       (stack_top),
    .full      (full),
    .empty     (empty)
  );

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      pc              <= PROG_START;
      ir_hi           <= '0;
      fault           <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_rd      <= 1'b0;
      bus.instruction <= '0;
      bus.control     <= '0;
      bus.exec        <= 1'b0;
      bus.vx_addr     <= '0;
      bus.vy_addr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state        <= F_HI;
            bus.mem_addr <= pc;
            bus.mem_rd   <= 1'b1;
          end
        end
        F_HI: begin
          state        <= F_LO;
          bus.mem_addr <= pc + ADDR_W'(1);
        end
        F_LO: begin
          state      <= F_WAIT;
          bus.mem_rd <= 1'b0;
          ir_hi      <= bus.mem_readdata;
        end
        F_WAIT: begin
          state           <= EXEC;
          bus.instruction <= {ir_hi, bus.mem_readdata};
          bus.exec        <= 1'b1;
          bus.control     <= '0;
          // Bnnn always adds V0, so its x field must not steer the register read.
          bus.vx_addr     <= (ir_hi[7:4] == OP_JPV0) ? 4'h0 : ir_hi[3:0];
          bus.vy_addr     <= bus.mem_readdata[7:4];
        end
        EXEC, MULTI: begin
          if (!last_step) begin
            state       <= MULTI;
            bus.control <= bus.control + 4'd1;
          end else begin
            bus.instruction <= '0;
            bus.exec        <= 1'b0;
            bus.control     <= '0;
            if (stack_fault) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              pc <= next_pc;
              if (run) begin
                state        <= F_HI;
                bus.mem_addr <= next_pc;
                bus.mem_rd   <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        FAULT:   state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_fetch_sequencer.sv
// Self-checking bench: directed scenarios plus a random opcode stream against an ISA-level PC/stack model.
module tb_chip8_fetch_sequencer;

  logic        cpu_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        run     = 1'b0;
  logic [11:0] pc;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  prog [4096];
  logic [7:0]  regs [16];
  logic [11:0] m_pc;
  logic [11:0] m_stack [$];

  chip8_fetch_sequencer_if bus ();

  chip8_fetch_sequencer dut (
    .cpu_clk (cpu_clk),
    .reset_n (reset_n),
    .run     (run),
    .bus     (bus),
    .pc      (pc),
    .fault   (fault)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Program memory with one cycle of read latency; register file read is same-cycle.
  always @(posedge cpu_clk)
    if (bus.mem_rd === 1'b1) bus.mem_readdata <= prog[bus.mem_addr];

  assign bus.vx_data = regs[bus.vx_addr];
  assign bus.vy_data = regs[bus.vy_addr];

  task automatic apply_reset();
    @(negedge cpu_clk);
    run     = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge cpu_clk);
    reset_n = 1'b1;
    m_pc    = 12'h200;
    m_stack.delete();
  endtask

  task automatic load_op(input logic [11:0] addr, input logic [15:0] op);
    prog[addr]         = op[15:8];
    prog[addr + 12'd1] = op[7:0];
  endtask

  // Instruction-set level model: returns the next PC, whether the op faults and how many exec cycles it takes.
  task automatic model_step(input logic [15:0] op, output logic [11:0] npc, output bit mfault, output int ncyc);
    logic [3:0]  x, y;
    logic [7:0]  kk;
    logic [11:0] nnn;
    x = op[11:8]; y = op[7:4]; kk = op[7:0]; nnn = op[11:0];
    mfault = 1'b0;
    ncyc   = 1;
    npc    = m_pc + 12'd2;
    if (op == 16'h00EE) begin
      if (m_stack.size() == 0) mfault = 1'b1;
      else npc = m_stack.pop_back();
    end else begin
      case (op[15:12])
        4'h1: npc = nnn;
        4'h2: begin
          if (m_stack.size() == 16) mfault = 1'b1;
          else begin
            m_stack.push_back(m_pc + 12'd2);
            npc = nnn;
          end
        end
        4'h3: if (regs[x] == kk) npc = m_pc + 12'd4;
        4'h4: if (regs[x] != kk) npc = m_pc + 12'd4;
        4'h5: if (op[3:0] == 4'h0 && regs[x] == regs[y]) npc = m_pc + 12'd4;
        4'h9: if (op[3:0] == 4'h0 && regs[x] != regs[y]) npc = m_pc + 12'd4;
        4'hB: npc = nnn + {4'h0, regs[0]};
        4'hF: if (kk == 8'h55 || kk == 8'h65) ncyc = int'(x) + 1;
        default: ;
      endcase
    end
    if (mfault) npc = m_pc;
    m_pc = npc;
  endtask

  // Pulses run for one cycle and records what the DUT presents during its exec window.
  task automatic exec_one(output logic [15:0] ins, output int ncyc, output bit ctl_ok, output bit held,
                          output logic [3:0] vxa, output logic [3:0] vya, output bit timeout);
    ins = '0; ncyc = 0; ctl_ok = 1'b1; held = 1'b1; vxa = '0; vya = '0; timeout = 1'b1;
    @(negedge cpu_clk); run = 1'b1;
    @(negedge cpu_clk); run = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge cpu_clk);
      if (bus.exec === 1'b1) begin
        if (ncyc == 0) begin
          ins = bus.instruction; vxa = bus.vx_addr; vya = bus.vy_addr;
        end else if (bus.instruction !== ins) held = 1'b0;
        if (bus.control !== 4'(ncyc)) ctl_ok = 1'b0;
        ncyc++;
      end else if (ncyc > 0) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (pc !== 12'h200) begin n_fail++; $display("FAIL reset_pc: got %h want 200", pc); end
    n_checks++; if (bus.instruction !== 16'h0) begin n_fail++; $display("FAIL reset_instruction: got %h want 0000", bus.instruction); end
    n_checks++; if ({bus.exec, bus.mem_rd, fault} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: exec/mem_rd/fault got %b want 000", {bus.exec, bus.mem_rd, fault}); end
    n_checks++; if ({bus.control, bus.vx_addr, bus.vy_addr} !== 12'h0) begin n_fail++; $display("FAIL reset_ctl_addr: got %h want 000", {bus.control, bus.vx_addr, bus.vy_addr}); end
    n_checks++; if (bus.mem_addr !== 12'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 000", bus.mem_addr); end
    repeat (3) @(negedge cpu_clk);
    n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL idle_no_fetch: mem_rd got %b want 0", bus.mem_rd); end
  endtask

  task automatic test_jump_timing();
    apply_reset();
    load_op(12'h200, 16'h1234);
    @(negedge cpu_clk); run = 1'b1;
    @(negedge cpu_clk);
    n_checks++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 12'h200}) begin n_fail++; $display("FAIL fetch_hi: rd/addr got %b/%h want 1/200", bus.mem_rd, bus.mem_addr); end
    @(negedge cpu_clk);
    n_checks++; if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 12'h201}) begin n_fail++; $display("FAIL fetch_lo: rd/addr got %b/%h want 1/201", bus.mem_rd, bus.mem_addr); end
    @(negedge cpu_clk);
    n_checks++; if ({bus.mem_rd, bus.exec} !== 2'b00) begin n_fail++; $display("FAIL fetch_wait: rd/exec got %b want 00", {bus.mem_rd, bus.exec}); end
    @(negedge cpu_clk); run = 1'b0;
    n_checks++; if ({bus.exec, bus.instruction} !== {1'b1, 16'h1234}) begin n_fail++; $display("FAIL jump_exec: exec/instr got %b/%h want 1/1234", bus.exec, bus.instruction); end
    @(negedge cpu_clk);
    n_checks++; if ({bus.exec, bus.instruction} !== {1'b0, 16'h0}) begin n_fail++; $display("FAIL jump_pulse: exec/instr got %b/%h want 0/0000", bus.exec, bus.instruction); end
    n_checks++; if (pc !== 12'h234) begin n_fail++; $display("FAIL jump_pc: got %h want 234", pc); end
  endtask

  task automatic test_skip();
    logic [15:0] ins; int ncyc; bit ctl_ok, held, to; logic [3:0] vxa, vya;
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      load_op(12'h200, 16'h3A05);
      regs[10] = (k == 0) ? 8'h05 : 8'h06;
      exec_one(ins, ncyc, ctl_ok, held, vxa, vya, to);
      n_checks++; if (vxa !== 4'hA) begin n_fail++; $display("FAIL skip_vx_addr: got %h want a", vxa); end
      n_checks++; if (pc !== ((k == 0) ? 12'h204 : 12'h202)) begin n_fail++; $display("FAIL skip_pc%0d: got %h want %h", k, pc, (k == 0) ? 12'h204 : 12'h202); end
    end
  endtask

  task automatic test_call_ret();
    logic [15:0] ins; int ncyc; bit ctl_ok, held, to; logic [3:0] vxa, vya;
    apply_reset();
    load_op(12'h200, 16'h2300);
    load_op(12'h300, 16'h00EE);
    exec_one(ins, ncyc, ctl_ok, held, vxa, vya, to);
    n_checks++; if (pc !== 12'h300) begin n_fail++; $display("FAIL call_pc: got %h want 300", pc); end
    exec_one(ins, ncyc, ctl_ok, held, vxa, vya, to);
    n_checks++; if ({fault, pc} !== {1'b0, 12'h202}) begin n_fail++; $display("FAIL ret_pc: fault/pc got %b/%h want 0/202", fault, pc); end
  endtask

  task automatic test_multi();
    logic [15:0] ins; int ncyc; bit ctl_ok, held, to; logic [3:0] vxa, vya;
    apply_reset();
    load_op(12'h200, 16'hF355);
    exec_one(ins, ncyc, ctl_ok, held, vxa, vya, to);
    n_checks++; if (ins !== 16'hF355 || !held) begin n_fail++; $display("FAIL multi_instr: got %h held=%0d want f355 held=1", ins, held); end
    n_checks++; if (ncyc !== 4 || !ctl_ok) begin n_fail++; $display("FAIL multi_steps: cycles %0d ctl_ok %0d want 4 and 1", ncyc, ctl_ok); end
    n_checks++; if ({pc, bus.control} !== {12'h202, 4'h0}) begin n_fail++; $display("FAIL multi_done: pc/control got %h/%h want 202/0", pc, bus.control); end
    apply_reset();
    load_op(12'h200, 16'hF065);
    exec_one(ins, ncyc, ctl_ok, held, vxa, vya, to);
    n_checks++; if (ncyc !== 1 || pc !== 12'h202) begin n_fail++; $display("FAIL multi_x0: cycles/pc got %0d/%h want 1/202", ncyc, pc); end
  endtask

  task automatic test_jpv0();
    logic [15:0] ins; int ncyc; bit ctl_ok, held, to; logic [3:0] vxa, vya;
    apply_reset();
    load_op(12'h200, 16'hB0FF);
    regs[0] = 8'h10;
    exec_one(ins, ncyc, ctl_ok, held, vxa, vya, to);
    n_checks++; if (pc !== 12'h10F) begin n_fail++; $display("FAIL jpv0_pc: got %h want 10f", pc); end
    apply_reset();
    load_op(12'h200, 16'hBFFF);
    regs[0] = 8'h02; regs[15] = 8'h77;
    exec_one(ins, ncyc, ctl_ok, held, vxa, vya, to);
    n_checks++; if ({vxa, pc} !== {4'h0, 12'h001}) begin n_fail++; $display("FAIL jpv0_wrap: vx_addr/pc got %h/%h want 0/001", vxa, pc); end
  endtask

  task automatic test_overflow();
    logic [15:0] ins; int ncyc; bit ctl_ok, held, to; logic [3:0] vxa, vya;
    int bad = 0;
    apply_reset();
    for (int i = 0; i < 17; i++) load_op(12'(12'h200 + 2 * i), {4'h2, 12'(12'h202 + 2 * i)});
    for (int i = 0; i < 16; i++) begin
      exec_one(ins, ncyc, ctl_ok, held, vxa, vya, to);
      n_checks++; if (pc !== 12'(12'h202 + 2 * i)) begin n_fail++; $display("FAIL nest_pc%0d: got %h want %h", i, pc, 12'(12'h202 + 2 * i)); end
    end
    exec_one(ins, ncyc, ctl_ok, held, vxa, vya, to);
    n_checks++; if ({fault, pc} !== {1'b1, 12'h220}) begin n_fail++; $display("FAIL overflow: fault/pc got %b/%h want 1/220", fault, pc); end
    run = 1'b1;
    repeat (8) begin
      @(negedge cpu_clk);
      if (bus.exec !== 1'b0 || bus.mem_rd !== 1'b0 || pc !== 12'h220) bad++;
    end
    run = 1'b0;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL fault_frozen: %0d active cycles want 0", bad); end
  endtask

  task automatic test_underflow();
    logic [15:0] ins; int ncyc; bit ctl_ok, held, to; logic [3:0] vxa, vya;
    apply_reset();
    load_op(12'h200, 16'h00EE);
    exec_one(ins, ncyc, ctl_ok, held, vxa, vya, to);
    n_checks++; if ({fault, pc} !== {1'b1, 12'h200}) begin n_fail++; $display("FAIL underflow: fault/pc got %b/%h want 1/200", fault, pc); end
  endtask

  task automatic test_reset_mid_multi();
    bit found = 1'b0;
    apply_reset();
    load_op(12'h200, 16'hF355);
    @(negedge cpu_clk); run = 1'b1;
    @(negedge cpu_clk); run = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge cpu_clk);
      if (bus.exec === 1'b1 && bus.control === 4'h2) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL mid_multi_reach: step 2 seen %0d want 1", found); end
    reset_n = 1'b0;
    #1;
    n_checks++; if ({bus.exec, bus.mem_rd, bus.control, bus.instruction} !== 22'h0) begin n_fail++; $display("FAIL mid_reset_out: got %h want 0", {bus.exec, bus.mem_rd, bus.control, bus.instruction}); end
    n_checks++; if (pc !== 12'h200) begin n_fail++; $display("FAIL mid_reset_pc: got %h want 200", pc); end
    @(negedge cpu_clk);
    reset_n = 1'b1;
    m_pc = 12'h200;
    m_stack.delete();
  endtask

  task automatic test_random();
    logic [15:0] op, ins; int ncyc, exp_cyc; bit ctl_ok, held, to, mf;
    logic [3:0] vxa, vya, x, y; logic [7:0] kk; logic [11:0] nnn, exp_pc;
    apply_reset();
    for (int it = 0; it < 120; it++) begin
      for (int r = 0; r < 16; r++) regs[r] = 8'($urandom);
      x = 4'($urandom); y = 4'($urandom); kk = 8'($urandom); nnn = 12'($urandom);
      case ($urandom_range(0, 9))
        0: op = {4'h1, nnn};
        1: op = {4'h2, nnn};
        2: op = 16'h00EE;
        3: begin op = {4'h3, x, kk}; if ($urandom_range(0, 1) == 1) regs[x] = kk; end
        4: begin op = {4'h4, x, kk}; if ($urandom_range(0, 1) == 1) regs[x] = kk; end
        5: begin
          op = {($urandom_range(0, 1) == 1) ? 4'h5 : 4'h9, x, y, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0};
          if ($urandom_range(0, 1) == 1) regs[y] = regs[x];
        end
        6: op = {4'hB, nnn};
        7: op = {4'hF, x, ($urandom_range(0, 1) == 1) ? 8'h55 : 8'h65};
        default: op = {4'($urandom_range(6, 8)), x, kk};
      endcase
      load_op(m_pc, op);
      model_step(op, exp_pc, mf, exp_cyc);
      exec_one(ins, ncyc, ctl_ok, held, vxa, vya, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL rnd%0d_timeout: exec window never closed for %h", it, op); end
      n_checks++; if (ins !== op || !held) begin n_fail++; $display("FAIL rnd%0d_instr: got %h held=%0d want %h", it, ins, held, op); end
      n_checks++; if (ncyc !== exp_cyc || !ctl_ok) begin n_fail++; $display("FAIL rnd%0d_cycles: got %0d ctl_ok=%0d want %0d (op %h)", it, ncyc, ctl_ok, exp_cyc, op); end
      n_checks++; if ({vxa, vya} !== {(op[15:12] == 4'hB) ? 4'h0 : op[11:8], op[7:4]}) begin n_fail++; $display("FAIL rnd%0d_regaddr: got %h%h for op %h", it, vxa, vya, op); end
      n_checks++; if ({fault, pc} !== {mf, exp_pc}) begin n_fail++; $display("FAIL rnd%0d_pc: fault/pc got %b/%h want %b/%h (op %h)", it, fault, pc, mf, exp_pc, op); end
      if (mf) apply_reset();
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) regs[r] = 8'h00;
    for (int a = 0; a < 4096; a++) prog[a] = 8'h00;
    test_reset();
    test_jump_timing();
    test_skip();
    test_call_ret();
    test_multi();
    test_jpv0();
    test_overflow();
    test_underflow();
    test_reset_mid_multi();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/chip8_fetch_sequencer.md
Name: chip8_fetch_sequencer

Overview:
- Instruction-side counterpart to the Chip8 execute datapath.
- Owns PC, call stack and fetch FSM; reads two bytes per opcode from program memory and presents the assembled 16-bit `instruction` to the combinational CPU.
- Steps the 4-bit CONTROL counter for the multicycle Fx55/Fx65 ops and drives the CPU's `testIn1`/`testIn2` register-address inputs.
- Resolves control flow itself: 00EE, 1nnn, 2nnn, 3xkk, 4xkk, 5xy0, 9xy0, Bnnn.

Parameters:
- PROG_START, 12'h200, PC value after reset.
- STACK_DEPTH, 16, call stack entries (12 bits each).
- ADDR_W, 12, memory address width.

Ports:
- cpu_clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  start a new fetch when high.
- mem_addr  out  12  program memory read address.
- mem_rd  out  1  read strobe.
- mem_readdata  in  8  read data, valid 1 cycle after mem_rd.
- instruction  out  16  opcode to CPU; 16'h0000 when not executing.
- control  out  4  multicycle step index to CPU CONTROL.
- exec  out  1  high during EXEC/MULTI cycles.
- vx_addr  out  4  to CPU testIn1; instruction[11:8], except 4'h0 for Bnnn.
- vy_addr  out  4  to CPU testIn2; instruction[7:4].
- vx_data  in  8  register file read of vx_addr, same cycle.
- vy_data  in  8  register file read of vy_addr, same cycle.
- pc  out  12  current program counter.
- fault  out  1  sticky stack overflow/underflow.

Behaviour:
- Reset (async assert, sync deassert use):
  - pc=PROG_START, sp=0, state=IDLE.
  - instruction=0, control=0, exec=0, mem_rd=0, mem_addr=0, fault=0.
  - vx_addr/vy_addr=0.
  - Stack contents are undefined.
- States:
  - IDLE: wait for run=1, then go to F_HI.
  - F_HI: mem_addr=pc, mem_rd=1.
  - F_LO: mem_addr=pc+1 (mod 4096), mem_rd=1; latch hi byte from mem_readdata.
  - F_WAIT: latch lo byte into the internal IR.
  - EXEC: instruction=IR, exec=1, for one cycle.
    - If IR is Fx55 or Fx65, go to MULTI.
    - Otherwise update pc (rules below), then go to F_HI if run=1, else IDLE.
  - MULTI: instruction=IR, exec=1, control increments by 1 per cycle starting at 0 (EXEC cycle = step 0).
    - When control==IR[11:8], pc+=2, control returns to 0, go to F_HI/IDLE.
    - F055 therefore takes a single step.
  - FAULT: terminal until reset; instruction=0, exec=0, mem_rd=0.
- Instruction period: 4 cycles for single-cycle ops; 4+x cycles for Fx55/Fx65.
- PC rules (applied at the end of the final exec cycle, all arithmetic mod 4096):
  - Default: pc+2.
  - 1nnn: pc=nnn.
  - 2nnn:
    - If sp==STACK_DEPTH: fault=1, go to FAULT, pc unchanged.
    - Else stack[sp]=pc+2, sp++, pc=nnn.
  - 00EE:
    - If sp==0: fault=1, go to FAULT.
    - Else sp--, pc=stack[sp].
  - 3xkk: pc+4 if vx_data==kk, else pc+2.
  - 4xkk: pc+4 if vx_data!=kk, else pc+2.
  - 5xy0: pc+4 if vx_data==vy_data, else pc+2.
  - 9xy0: pc+4 if vx_data!=vy_data, else pc+2.
  - Bnnn: pc = nnn + vx_data (V0), 12-bit wrap.
  - 5xyN/9xyN with N!=0: treated as default pc+2.
- vx_data/vy_data are sampled combinationally in EXEC; the register file read is same-cycle.
- run deasserted mid-instruction: the current instruction completes; the next fetch is withheld (state IDLE).
- Simultaneous reset and any state: reset wins; an in-flight push/pop is discarded.

Decomposition:
- Shared package chip8_pkg:
  - state enum typedef (IDLE, F_HI, F_LO, F_WAIT, EXEC, MULTI, FAULT).
  - opcode-class constants: OP_JP=4'h1, OP_CALL=4'h2, OP_SE=4'h3, OP_SNE=4'h4, OP_SEV=4'h5, OP_SNEV=4'h9, OP_JPV0=4'hB, OP_F=4'hF.
  - FN_STORE=8'h55, FN_LOAD=8'h65, INSTR_RET=16'h00EE.
  - PROG_START default.
- One sub-module, chip8_call_stack:
  - 16x12 LIFO with push/pop/sp.
  - full and empty flags.
  - Async active-low reset of sp only.

Test Plan:
- Reset, run=1, memory[0x200..0x201]=12,34 -> mem_addr 0x200 then 0x201; instruction=16'h1234 (1-cycle exec pulse) in cycle 4; pc=0x234 afterwards.
- 3A05 at 0x200 with vx_data=8'h05 -> vx_addr=4'hA; next pc=0x204. Repeat with vx_data=8'h06 -> next pc=0x202.
- 2300 at 0x200, then 00EE at 0x300 -> pc=0x300, sp=1; then pc=0x202, sp=0.
- 17 nested 2nnn calls -> 17th asserts fault, exec stays 0, mem_rd stays 0, pc frozen. Separately, 00EE with sp=0 -> fault=1.
- F355 at 0x200 -> instruction held at 16'hF355 for 4 cycles; control sequence 0,1,2,3; then pc=0x202, control=0.
- Bnnn B0FF with V0=8'h10 -> pc=0x10F. B FFF with V0=8'h02 -> pc wraps to 0x001.
- reset_n pulsed low during MULTI step 2 -> outputs immediately return to reset values; pc=0x200.
